// File: rtl/signal_edge_detector.sv
// Per-bit rising-edge pulse generator with an optional input synchronizer chain.
// Define SIGNAL_EDGE_FALL_EN to also generate falling-edge pulses on fall_pulse/any_edge.
module signal_edge_detector #(
  parameter int   WIDTH       = 1,
  parameter int   SYNC_STAGES = 0,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] any_edge
);

  localparam logic [WIDTH-1:0] INIT_VEC = {WIDTH{INIT_LEVEL}};

  logic [WIDTH-1:0] prev;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign level_out = sig_in;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= INIT_VEC;
        end else begin
          sync_q[0] <= sig_in;
          for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
      end

      assign level_out = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) prev <= INIT_VEC;
    else     prev <= level_out;
  end

  // Pulses are gated by rst so nothing escapes while history is being cleared.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      assign rise_pulse[i] = ~rst & level_out[i] & ~prev[i];
`ifdef SIGNAL_EDGE_FALL_EN
      assign fall_pulse[i] = ~rst & ~level_out[i] & prev[i];
      assign any_edge[i]   = rise_pulse[i] | fall_pulse[i];
`else
      assign fall_pulse[i] = 1'b0;
      assign any_edge[i]   = rise_pulse[i];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_signal_edge_detector.sv
// Bench for signal_edge_detector: three instances cover direct/4-bit, 2-stage sync and INIT_LEVEL=1.
// Expectations follow SIGNAL_EDGE_FALL_EN when it is defined for the build.
module tb_signal_edge_detector;

`ifdef SIGNAL_EDGE_FALL_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_a, rst_b, rst_c;
  logic [3:0] sig_a, level_a, rise_a, fall_a, any_a;
  logic       sig_b, level_b, rise_b, fall_b, any_b;
  logic       sig_c, level_c, rise_c, fall_c, any_c;

  logic [15:0] exp_a_q[$];
  logic [3:0]  exp_b_q[$];
  logic [3:0]  exp_c_q[$];

  int vectors;
  int miscompares;

  signal_edge_detector #(.WIDTH(4), .SYNC_STAGES(0), .INIT_LEVEL(1'b0)) u_a (
    .clk(clk), .rst(rst_a), .sig_in(sig_a), .level_out(level_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a), .any_edge(any_a)
  );

  signal_edge_detector #(.WIDTH(1), .SYNC_STAGES(2), .INIT_LEVEL(1'b0)) u_b (
    .clk(clk), .rst(rst_b), .sig_in(sig_b), .level_out(level_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .any_edge(any_b)
  );

  signal_edge_detector #(.WIDTH(1), .SYNC_STAGES(0), .INIT_LEVEL(1'b1)) u_c (
    .clk(clk), .rst(rst_c), .sig_in(sig_c), .level_out(level_c),
    .rise_pulse(rise_c), .fall_pulse(fall_c), .any_edge(any_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {level, rise, fall, any}; fall is forced to 0 when falling edges are disabled.
  function automatic logic [15:0] pack_a(input logic [3:0] lvl, input logic [3:0] r,
                                         input logic [3:0] f);
    logic [3:0] fe;
    fe = FALL_EN ? f : 4'b0000;
    return {lvl, r, fe, r | fe};
  endfunction

  function automatic logic [3:0] pack_1(input logic lvl, input logic r, input logic f);
    logic fe;
    fe = FALL_EN ? f : 1'b0;
    return {lvl, r, fe, r | fe};
  endfunction

  task automatic test_reset();
    logic [15:0] got_a, e_a;
    logic [3:0]  got_b, e_b, got_c, e_c;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    sig_a = 4'b1111; sig_b = 1'b0; sig_c = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 2; n++) begin
      exp_a_q.push_back(pack_a(4'b1111, 4'b0000, 4'b0000));
      exp_b_q.push_back(pack_1(1'b0, 1'b0, 1'b0));
      exp_c_q.push_back(pack_1(1'b1, 1'b0, 1'b0));
      @(negedge clk);
      got_a = {level_a, rise_a, fall_a, any_a}; e_a = exp_a_q.pop_front(); vectors++;
      if (got_a !== e_a) begin
        miscompares++;
        $display("FAIL reset_a cycle %0d: got %h expected %h", n, got_a, e_a);
      end
      got_b = {level_b, rise_b, fall_b, any_b}; e_b = exp_b_q.pop_front(); vectors++;
      if (got_b !== e_b) begin
        miscompares++;
        $display("FAIL reset_b cycle %0d: got %h expected %h", n, got_b, e_b);
      end
      got_c = {level_c, rise_c, fall_c, any_c}; e_c = exp_c_q.pop_front(); vectors++;
      if (got_c !== e_c) begin
        miscompares++;
        $display("FAIL reset_c cycle %0d: got %h expected %h", n, got_c, e_c);
      end
      @(posedge clk); #1;
    end
  endtask

  // Input held high through reset: one pulse with INIT_LEVEL=0, none with INIT_LEVEL=1.
  task automatic test_init_level();
    logic [3:0] stim_a [4] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000};
    logic [3:0] er_a   [4] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] ef_a   [4] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000};
    logic       stim_c [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       ef_c   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] got_a, e_a;
    logic [3:0]  got_c, e_c;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    for (int n = 0; n < 4; n++) begin
      sig_a = stim_a[n];
      sig_c = stim_c[n];
      exp_a_q.push_back(pack_a(stim_a[n], er_a[n], ef_a[n]));
      exp_c_q.push_back(pack_1(stim_c[n], 1'b0, ef_c[n]));
      @(negedge clk);
      got_a = {level_a, rise_a, fall_a, any_a}; e_a = exp_a_q.pop_front(); vectors++;
      if (got_a !== e_a) begin
        miscompares++;
        $display("FAIL init_level_a cycle %0d: got %h expected %h", n, got_a, e_a);
      end
      got_c = {level_c, rise_c, fall_c, any_c}; e_c = exp_c_q.pop_front(); vectors++;
      if (got_c !== e_c) begin
        miscompares++;
        $display("FAIL init_level_c cycle %0d: got %h expected %h", n, got_c, e_c);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rise_hold();
    logic [15:0] got, e;
    for (int n = 0; n < 20; n++) begin
      sig_a = 4'b0001;
      exp_a_q.push_back(pack_a(4'b0001, (n == 0) ? 4'b0001 : 4'b0000, 4'b0000));
      @(negedge clk);
      got = {level_a, rise_a, fall_a, any_a}; e = exp_a_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL rise_hold cycle %0d: got %h expected %h", n, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multi_bit();
    logic [3:0] stim [4] = '{4'b0000, 4'b0101, 4'b1100, 4'b1100};
    logic [3:0] er   [4] = '{4'b0000, 4'b0101, 4'b1000, 4'b0000};
    logic [3:0] ef   [4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    logic [15:0] got, e;
    for (int n = 0; n < 4; n++) begin
      sig_a = stim[n];
      exp_a_q.push_back(pack_a(stim[n], er[n], ef[n]));
      @(negedge clk);
      got = {level_a, rise_a, fall_a, any_a}; e = exp_a_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL multi_bit cycle %0d: got %h expected %h", n, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_toggle();
    logic [15:0] got, e;
    logic [3:0]  s;
    for (int n = 0; n < 8; n++) begin
      s = (n % 2 == 0) ? 4'b1101 : 4'b1100;
      sig_a = s;
      exp_a_q.push_back(pack_a(s, (n % 2 == 0) ? 4'b0001 : 4'b0000,
                               (n % 2 == 1) ? 4'b0001 : 4'b0000));
      @(negedge clk);
      got = {level_a, rise_a, fall_a, any_a}; e = exp_a_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL toggle cycle %0d: got %h expected %h", n, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  // Includes a reset landing on the same cycle as a falling edge, which must be swallowed.
  task automatic test_mid_reset();
    logic [3:0] stim [8] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111,
                             4'b1111, 4'b0000, 4'b0000, 4'b0000};
    logic       rs   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] er   [8] = '{4'b0011, 4'b0000, 4'b0000, 4'b1111,
                             4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [15:0] got, e;
    for (int n = 0; n < 8; n++) begin
      sig_a = stim[n];
      rst_a = rs[n];
      exp_a_q.push_back(pack_a(stim[n], er[n], 4'b0000));
      @(negedge clk);
      got = {level_a, rise_a, fall_a, any_a}; e = exp_a_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL mid_reset cycle %0d: got %h expected %h", n, got, e);
      end
      @(posedge clk); #1;
    end
    rst_a = 1'b0;
  endtask

  // Two-stage synchronizer latency, then a sub-cycle glitch that no posedge samples.
  task automatic test_sync();
    logic stim [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic el   [13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic er   [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic ef   [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] got, e;
    for (int n = 0; n < 13; n++) begin
      sig_b = stim[n];
      exp_b_q.push_back(pack_1(el[n], er[n], ef[n]));
      if (n == 9) begin
        #1 sig_b = 1'b1;
        #2 sig_b = 1'b0;
      end
      @(negedge clk);
      got = {level_b, rise_b, fall_b, any_b}; e = exp_b_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL sync cycle %0d: got %h expected %h", n, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_init_level();
    test_rise_hold();
    test_multi_bit();
    test_toggle();
    test_mid_reset();
    test_sync();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
